// File: rtl/riscv_pkg.sv
// Shared RV32 constants: canonical NOP, base opcodes and the fetch FSM state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID register, 1 instr / 2 cycles at zero wait.
// Decode stall parks a late response in a one-entry hold buffer; redirect drops in-flight responses.
module fetch_stage
    import riscv_pkg::fetch_state_t, riscv_pkg::S_IDLE, riscv_pkg::S_REQ,
           riscv_pkg::S_WAIT, riscv_pkg::S_HOLD;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic         r_drop;
    logic [31:0]  r_hold_inst;
    logic [31:0]  r_hold_pc;
    logic         r_if_valid;
    logic [31:0]  r_if_inst;
    logic [31:0]  r_if_pc;

    logic [31:0]  w_redirect_pc;
    logic         w_slot_free;
    logic         w_rsp_take;
    logic         w_load_new;
    logic         w_capture;
    logic         w_load_hold;
    logic         w_squash;

    assign w_redirect_pc = redirect_pc_i & ~32'd3;
    assign w_squash      = redirect_i | flush_i;
    assign w_slot_free   = !r_if_valid || !stall_i;

    // A response survives only if not marked stale and not squashed in its arrival cycle.
    assign w_rsp_take  = (r_state == S_WAIT) && imem_rvalid && !r_drop && !w_squash;
    assign w_load_new  = w_rsp_take && w_slot_free;
    assign w_capture   = w_rsp_take && !w_slot_free;
    assign w_load_hold = (r_state == S_HOLD) && !stall_i && !w_squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_drop   <= redirect_i;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= w_capture ? S_HOLD : S_REQ;
                    end else if (redirect_i) begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_squash || !stall_i) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (redirect_i) begin
                r_pc <= w_redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_inst <= NOP_INST;
            r_hold_pc   <= RESET_PC;
        end else if (w_capture) begin
            r_hold_inst <= imem_rdata;
            r_hold_pc   <= r_req_pc;
        end
    end

    // IF/ID: squash beats load, load beats stall-hold; PC is kept across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= RESET_PC;
        end else if (w_squash) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
        end else if (w_load_new) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= imem_rdata;
            r_if_pc    <= r_req_pc;
        end else if (w_load_hold) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= r_hold_inst;
            r_if_pc    <= r_hold_pc;
        end else if (!(stall_i && r_if_valid)) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign if_valid_o = r_if_valid;
    assign if_inst_o  = r_if_inst;
    assign if_pc_o    = r_if_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a responder returning rdata = fetch address after 1 or 2 cycles.
`timescale 1ns/100ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;

    int checks = 0;
    int errors = 0;

    logic        mem_lat2 = 1'b0;
    logic        mem_rv = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [31:0] a1 = 32'h0, a2 = 32'h0;
    logic        frc_rv = 1'b0;
    logic [31:0] frc_rdata = 32'h0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o)
    );

    always #5 clk = ~clk;

    // Responder: a grant seen in cycle N returns rvalid in cycle N+1 (or N+2 when mem_lat2).
    always @(negedge clk) begin
        mem_rv    = mem_lat2 ? p2 : p1;
        mem_rdata = mem_lat2 ? a2 : a1;
        p2 = p1;
        a2 = a1;
        p1 = imem_req && imem_gnt && rst_n;
        a1 = imem_addr;
    end

    assign imem_rvalid = mem_rv | frc_rv;
    assign imem_rdata  = frc_rv ? frc_rdata : mem_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, v});
        chk({tag, ".inst"}, if_inst_o, inst);
        chk({tag, ".pc"}, if_pc_o, pc);
    endtask

    initial begin
        rst_n = 1'b1;
        imem_gnt = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        #1 rst_n = 1'b0;
        step();
        step();
        chk_out("rst", 1'b0, 32'h13, 32'h0);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch: first valid on the third edge after release.
        step();
        chk("e1.req", {31'd0, imem_req}, 32'd1);
        chk("e1.addr", imem_addr, 32'h0);
        chk("e1.valid", {31'd0, if_valid_o}, 32'd0);
        step();
        chk("e2.req", {31'd0, imem_req}, 32'd0);
        chk("e2.valid", {31'd0, if_valid_o}, 32'd0);
        step();
        chk_out("e3", 1'b1, 32'h0, 32'h0);
        chk("e3.addr", imem_addr, 32'h4);
        step();
        chk_out("e4", 1'b0, 32'h13, 32'h0);
        step();
        chk_out("e5", 1'b1, 32'h4, 32'h4);

        // Stall for 5 cycles: IF/ID holds 0x4, next response parks, no new request.
        stall_i = 1'b1;
        step();
        chk_out("stall1", 1'b1, 32'h4, 32'h4);
        chk("stall1.req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stallN", 1'b1, 32'h4, 32'h4);
            chk("stallN.req", {31'd0, imem_req}, 32'd0);
        end
        stall_i = 1'b0;
        step();
        chk_out("unstall", 1'b1, 32'h8, 32'h8);
        chk("unstall.req", {31'd0, imem_req}, 32'd1);
        chk("unstall.addr", imem_addr, 32'hC);

        // Flush while stalled with a valid entry: bubble, then fetch continues at 0xC.
        stall_i = 1'b1;
        flush_i = 1'b1;
        step();
        chk_out("flush", 1'b0, 32'h13, 32'h8);
        stall_i = 1'b0;
        flush_i = 1'b0;
        step();
        chk_out("postflush", 1'b1, 32'hC, 32'hC);
        step();
        chk("w14.req", {31'd0, imem_req}, 32'd0);

        // Redirect in S_WAIT before the (slow) response: 0x10 must be dropped.
        mem_lat2 = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        step();
        chk_out("rdw", 1'b0, 32'h13, 32'hC);
        chk("rdw.req", {31'd0, imem_req}, 32'd0);
        redirect_i = 1'b0;
        step();
        chk("rdw.drop.valid", {31'd0, if_valid_o}, 32'd0);
        chk("rdw.req2", {31'd0, imem_req}, 32'd1);
        chk("rdw.addr", imem_addr, 32'h100);
        mem_lat2 = 1'b0;
        step();
        chk("rdw.wait.valid", {31'd0, if_valid_o}, 32'd0);
        step();
        chk_out("rdw.tgt", 1'b1, 32'h100, 32'h100);
        chk("rdw.next", imem_addr, 32'h104);

        // Redirect coincident with grant: response for 0x104 dropped.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        chk_out("rdg", 1'b0, 32'h13, 32'h100);
        redirect_i = 1'b0;
        step();
        chk("rdg.drop.valid", {31'd0, if_valid_o}, 32'd0);
        chk("rdg.req", {31'd0, imem_req}, 32'd1);
        chk("rdg.addr", imem_addr, 32'h200);
        step();
        chk("rdg.wait.valid", {31'd0, if_valid_o}, 32'd0);
        step();
        chk_out("rdg.tgt", 1'b1, 32'h200, 32'h200);

        // No grant: address held; redirect in S_REQ retargets with low bits cleared, PC wraps.
        imem_gnt = 1'b0;
        step();
        chk("nognt.req", {31'd0, imem_req}, 32'd1);
        chk("nognt.addr", imem_addr, 32'h204);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        step();
        chk("rdr.req", {31'd0, imem_req}, 32'd1);
        chk("rdr.addr", imem_addr, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        imem_gnt = 1'b1;
        step();
        chk("wrap.req", {31'd0, imem_req}, 32'd0);
        step();
        chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap.addr", imem_addr, 32'h0);

        // Reset in S_WAIT; stray rvalid afterwards is ignored.
        step();
        chk("prerst.req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 32'h13, 32'h0);
        chk("arst.req", {31'd0, imem_req}, 32'd0);
        chk("arst.addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        frc_rdata = 32'hDEAD_BEE0;
        frc_rv = 1'b1;
        step();
        chk_out("stray.idle", 1'b0, 32'h13, 32'h0);
        chk("stray.req", {31'd0, imem_req}, 32'd1);
        chk("stray.addr", imem_addr, 32'h0);
        step();
        chk("stray.req2", {31'd0, imem_req}, 32'd0);
        chk("stray.valid", {31'd0, if_valid_o}, 32'd0);
        frc_rv = 1'b0;
        step();
        chk_out("rst.first", 1'b1, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
